ifft: RTL and testbench

IFFT -- requirements
Module: ifft

---
 rtl/ifft.sv | 240 ++++++++++++++++++++++++
 tb/tb_ifft.sv | 461 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifft.sv
// -----------------------------------------------------------------------------
// ifft -- 8-point radix-2 decimation-in-time inverse DFT, Q8.8 fixed point.
//
// One transform takes six cycles: a capture edge in IDLE, three butterfly
// stages, a scaling edge that writes the outputs, and a DONE cycle. All eight
// complex points live in a single bank of stage registers. Each stage rewrites
// that bank in place.
//
// Ports
//   clk            : single clock, rising-edge active
//   rst            : asynchronous active-high reset, clears all state
//   start          : run one transform; honoured only in IDLE
//   X_real/X_imag  : 8 x 16-bit signed Q8.8 frequency-domain input
//   x_real/x_imag  : 8 x 16-bit signed Q8.8 time-domain output, registered,
//                    held between completions
//   busy           : high whenever the FSM is not in IDLE
//   done           : registered one-cycle pulse marking fresh outputs
// -----------------------------------------------------------------------------
module ifft (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic signed [15:0] X_real [0:7],
    input  logic signed [15:0] X_imag [0:7],
    output logic signed [15:0] x_real [0:7],
    output logic signed [15:0] x_imag [0:7],
    output logic               busy,
    output logic               done
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        STAGE0 = 3'd1,
        STAGE1 = 3'd2,
        STAGE2 = 3'd3,
        SCALE  = 3'd4,
        DONE   = 3'd5
    } state_t;

    typedef struct packed {
        logic signed [15:0] re;
        logic signed [15:0] im;
    } cplx_t;

    // The two butterfly results: out1 = a + w*b, out2 = a - w*b.
    typedef struct packed {
        cplx_t out1;
        cplx_t out2;
    } bfly_t;

    // -------------------------------------------------------------------------
    // Arithmetic helpers
    // -------------------------------------------------------------------------

    // Bit reversal of a 3-bit index: b2 b1 b0 -> b0 b1 b2.
    function automatic logic [2:0] rev3(input logic [2:0] i);
        return {i[0], i[1], i[2]};
    endfunction

    // Inverse twiddle W8^(-k) for k = 0..3, in Q8.8.
    function automatic cplx_t twiddle(input logic [1:0] k);
        cplx_t w;
        unique case (k)
            2'd0: begin w.re = 16'sh0100; w.im = 16'sh0000; end
            2'd1: begin w.re = 16'sh00B5; w.im = 16'sh00B5; end
            2'd2: begin w.re = 16'sh0000; w.im = 16'sh0100; end
            default: begin w.re = 16'shFF4B; w.im = 16'sh00B5; end
        endcase
        return w;
    endfunction

    // Q8.8 complex multiply. The sums are formed at full 32-bit precision.
    // Dropping the low eight bits with an arithmetic shift truncates toward -inf.
    function automatic cplx_t cmul(input cplx_t w, input cplx_t b);
        logic signed [31:0] wr;
        logic signed [31:0] wi;
        logic signed [31:0] br;
        logic signed [31:0] bi;
        logic signed [31:0] pr;
        logic signed [31:0] pi;
        cplx_t              r;
        wr   = {{16{w.re[15]}}, w.re};
        wi   = {{16{w.im[15]}}, w.im};
        br   = {{16{b.re[15]}}, b.re};
        bi   = {{16{b.im[15]}}, b.im};
        pr   = (wr * br) - (wi * bi);
        pi   = (wr * bi) + (wi * br);
        r.re = 16'(pr >>> 8);
        r.im = 16'(pi >>> 8);
        return r;
    endfunction

    // Radix-2 butterfly. The 16-bit add and subtract wrap on overflow by design.
    function automatic bfly_t bfly(input cplx_t a, input cplx_t b, input cplx_t w);
        cplx_t t;
        bfly_t r;
        t         = cmul(w, b);
        r.out1.re = a.re + t.re;
        r.out1.im = a.im + t.im;
        r.out2.re = a.re - t.re;
        r.out2.im = a.im - t.im;
        return r;
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t             state_q, state_d;
    logic               done_q,  done_d;
    cplx_t              data_q [8];
    cplx_t              data_d [8];
    logic signed [15:0] xr_q   [8];
    logic signed [15:0] xr_d   [8];
    logic signed [15:0] xi_q   [8];
    logic signed [15:0] xi_d   [8];

    // -------------------------------------------------------------------------
    // Next-state and datapath
    // -------------------------------------------------------------------------
    always_comb begin
        bfly_t r;
        // NOTE: every variable gets a hold/default value before the case
        // statement, so no path through the block leaves one unassigned and
        // no latch is inferred.
        state_d = state_q;
        done_d  = 1'b0;
        r       = '0;
        for (int i = 0; i < 8; i++) begin
            data_d[i] = data_q[i];
            xr_d[i]   = xr_q[i];
            xi_d[i]   = xi_q[i];
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = STAGE0;
                    // Bit-reversed load, so the DIT stages emit natural order.
                    for (int i = 0; i < 8; i++) begin
                        data_d[i].re = X_real[rev3(3'(i))];
                        data_d[i].im = X_imag[rev3(3'(i))];
                    end
                end
            end

            // Span-1 butterflies: (0,1) (2,3) (4,5) (6,7), all W^0.
            STAGE0: begin
                state_d = STAGE1;
                for (int p = 0; p < 4; p++) begin
                    r = bfly(data_q[2*p], data_q[2*p+1], twiddle(2'd0));
                    data_d[2*p]   = r.out1;
                    data_d[2*p+1] = r.out2;
                end
            end

            // Span-2 butterflies: (0,2) (4,6) with W^0, (1,3) (5,7) with W^-2.
            STAGE1: begin
                state_d = STAGE2;
                for (int g = 0; g < 2; g++) begin
                    for (int j = 0; j < 2; j++) begin
                        r = bfly(data_q[4*g+j], data_q[4*g+j+2], twiddle(2'(2*j)));
                        data_d[4*g+j]   = r.out1;
                        data_d[4*g+j+2] = r.out2;
                    end
                end
            end

            // Span-4 butterflies: (j, j+4) with W^-j.
            STAGE2: begin
                state_d = SCALE;
                for (int j = 0; j < 4; j++) begin
                    r = bfly(data_q[j], data_q[j+4], twiddle(2'(j)));
                    data_d[j]   = r.out1;
                    data_d[j+4] = r.out2;
                end
            end

            // The 1/8 normalisation is an arithmetic shift, so it rounds toward -inf.
            SCALE: begin
                state_d = DONE;
                done_d  = 1'b1;
                for (int i = 0; i < 8; i++) begin
                    xr_d[i] = data_q[i].re >>> 3;
                    xi_d[i] = data_q[i].im >>> 3;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    // NOTE: state is updated only with non-blocking assignments. Every flop
    // then samples values from before the edge, whatever order the
    // statements are in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
            // NOTE: the stage bank is only eight entries and must read as zero
            // after reset, so it is reset like ordinary flops. It is not left
            // to a RAM.
            for (int i = 0; i < 8; i++) begin
                data_q[i] <= '0;
                xr_q[i]   <= '0;
                xi_q[i]   <= '0;
            end
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            for (int i = 0; i < 8; i++) begin
                data_q[i] <= data_d[i];
                xr_q[i]   <= xr_d[i];
                xi_q[i]   <= xi_d[i];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            x_real[i] = xr_q[i];
            x_imag[i] = xi_q[i];
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;

endmodule

// File: tb/tb_ifft.sv
// -----------------------------------------------------------------------------
// tb_ifft -- directed self-checking bench for the 8-point inverse FFT.
//
// Inputs are driven and outputs are sampled on the falling clock edge. Each
// input set has expected outputs worked out by hand through the Q8.8 datapath.
// -----------------------------------------------------------------------------
module tb_ifft;

    logic               clk;
    logic               rst;
    logic               start;
    logic signed [15:0] X_real [0:7];
    logic signed [15:0] X_imag [0:7];
    logic signed [15:0] x_real [0:7];
    logic signed [15:0] x_imag [0:7];
    logic               busy;
    logic               done;

    int checks   = 0;
    int failures = 0;

    // Input sets and their hand-derived outputs.
    //   0 constant spectrum, 1 DC, 2 sine, 3 unit bin 1,
    //   4 small bin 1 (multiply truncation), 5 adder wrap-around
    logic signed [15:0] vin_re  [6][8];
    logic signed [15:0] vin_im  [6][8];
    logic signed [15:0] vexp_re [6][8];
    logic signed [15:0] vexp_im [6][8];

    ifft dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .X_real (X_real),
        .X_imag (X_imag),
        .x_real (x_real),
        .x_imag (x_imag),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global watchdog so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic init_vectors();
        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < 8; i++) begin
                vin_re[v][i]  = '0;
                vin_im[v][i]  = '0;
                vexp_re[v][i] = '0;
                vexp_im[v][i] = '0;
            end
        end
        for (int i = 0; i < 8; i++) vin_re[0][i] = 16'sh0100;
        vexp_re[0][0] = 16'sh0100;

        vin_re[1][0] = 16'sh0800;
        for (int i = 0; i < 8; i++) vexp_re[1][i] = 16'sh0100;

        vin_im[2][1] = 16'shFC00;
        vin_im[2][7] = 16'sh0400;
        vexp_re[2] = '{16'sh0000, 16'sh00B5, 16'sh0100, 16'sh00B5,
                       16'sh0000, 16'shFF4B, 16'shFF00, 16'shFF4B};

        vin_re[3][1] = 16'sh0100;
        vexp_re[3] = '{16'sh0020, 16'sh0016, 16'sh0000, 16'shFFE9,
                       16'shFFE0, 16'shFFE9, 16'sh0000, 16'sh0016};
        vexp_im[3] = '{16'sh0000, 16'sh0016, 16'sh0020, 16'sh0016,
                       16'sh0000, 16'shFFE9, 16'shFFE0, 16'shFFE9};

        vin_re[4][1] = 16'sh000C;
        vexp_re[4] = '{16'sh0001, 16'sh0001, 16'sh0000, 16'shFFFE,
                       16'shFFFE, 16'shFFFF, 16'sh0000, 16'sh0001};
        vexp_im[4] = '{16'sh0000, 16'sh0001, 16'sh0001, 16'sh0001,
                       16'sh0000, 16'shFFFF, 16'shFFFE, 16'shFFFF};

        vin_re[5][0] = 16'sh4000;
        vin_re[5][4] = 16'sh4000;
        vexp_re[5] = '{16'shF000, 16'sh0000, 16'shF000, 16'sh0000,
                       16'shF000, 16'sh0000, 16'shF000, 16'sh0000};
    endtask

    task automatic apply_inputs(input int v);
        for (int i = 0; i < 8; i++) begin
            X_real[i] = vin_re[v][i];
            X_imag[i] = vin_im[v][i];
        end
    endtask

    // Called on a falling edge. It pulses start for one cycle and waits a
    // bounded time for done. lat returns the number of rising edges after the
    // accept edge, or -1 if done never came.
    task automatic run_vec(input int v, output int lat);
        int cnt;
        apply_inputs(v);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cnt   = 1;
        while (done !== 1'b1 && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        lat = (done === 1'b1) ? cnt - 1 : -1;
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        apply_inputs(0);
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl busy=%b done=%b required 0 0", busy, done);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (x_real[i] !== 16'sh0000 || x_imag[i] !== 16'sh0000) begin
                failures++;
                $display("FAIL reset_out[%0d] got %h/%h required 0000/0000",
                         i, x_real[i], x_imag[i]);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_constant();
        int lat;
        run_vec(0, lat);
        checks++;
        if (lat !== 4) begin
            failures++;
            $display("FAIL const_latency got %0d required 4", lat);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (x_real[i] !== vexp_re[0][i] || x_imag[i] !== vexp_im[0][i]) begin
                failures++;
                $display("FAIL const_out[%0d] got %h/%h required %h/%h",
                         i, x_real[i], x_imag[i], vexp_re[0][i], vexp_im[0][i]);
            end
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL const_done_width done=%b busy=%b required 0 0", done, busy);
        end
    endtask

    task automatic test_dc();
        int lat;
        run_vec(1, lat);
        checks++;
        if (lat !== 4) begin
            failures++;
            $display("FAIL dc_latency got %0d required 4", lat);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (x_real[i] !== vexp_re[1][i] || x_imag[i] !== vexp_im[1][i]) begin
                failures++;
                $display("FAIL dc_out[%0d] got %h/%h required %h/%h",
                         i, x_real[i], x_imag[i], vexp_re[1][i], vexp_im[1][i]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_sine();
        int lat;
        int dr;
        int di;
        run_vec(2, lat);
        checks++;
        if (lat !== 4) begin
            failures++;
            $display("FAIL sine_latency got %0d required 4", lat);
        end
        for (int i = 0; i < 8; i++) begin
            dr = int'(x_real[i]) - int'(vexp_re[2][i]);
            di = int'(x_imag[i]) - int'(vexp_im[2][i]);
            checks++;
            if (dr > 2 || dr < -2 || di > 2 || di < -2) begin
                failures++;
                $display("FAIL sine_out[%0d] got %h/%h required %h/%h +/-2",
                         i, x_real[i], x_imag[i], vexp_re[2][i], vexp_im[2][i]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_bin1_floor();
        int lat;
        run_vec(3, lat);
        checks++;
        if (lat !== 4) begin
            failures++;
            $display("FAIL bin1_latency got %0d required 4", lat);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (x_real[i] !== vexp_re[3][i] || x_imag[i] !== vexp_im[3][i]) begin
                failures++;
                $display("FAIL bin1_out[%0d] got %h/%h required %h/%h",
                         i, x_real[i], x_imag[i], vexp_re[3][i], vexp_im[3][i]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_mult_truncation();
        int lat;
        run_vec(4, lat);
        checks++;
        if (lat !== 4) begin
            failures++;
            $display("FAIL trunc_latency got %0d required 4", lat);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (x_real[i] !== vexp_re[4][i] || x_imag[i] !== vexp_im[4][i]) begin
                failures++;
                $display("FAIL trunc_out[%0d] got %h/%h required %h/%h",
                         i, x_real[i], x_imag[i], vexp_re[4][i], vexp_im[4][i]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_wrap();
        int lat;
        run_vec(5, lat);
        checks++;
        if (lat !== 4) begin
            failures++;
            $display("FAIL wrap_latency got %0d required 4", lat);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (x_real[i] !== vexp_re[5][i] || x_imag[i] !== vexp_im[5][i]) begin
                failures++;
                $display("FAIL wrap_out[%0d] got %h/%h required %h/%h",
                         i, x_real[i], x_imag[i], vexp_re[5][i], vexp_im[5][i]);
            end
        end
        @(negedge clk);
    endtask

    // Without start, new inputs must not be captured and outputs must hold.
    task automatic test_hold_no_start();
        int ndone = 0;
        apply_inputs(1);
        start = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) ndone++;
        end
        checks++;
        if (ndone != 0) begin
            failures++;
            $display("FAIL hold_activity got %0d active cycles required 0", ndone);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (x_real[i] !== vexp_re[5][i] || x_imag[i] !== vexp_im[5][i]) begin
                failures++;
                $display("FAIL hold_out[%0d] got %h/%h required %h/%h",
                         i, x_real[i], x_imag[i], vexp_re[5][i], vexp_im[5][i]);
            end
        end
    endtask

    // A second start at E2 with new inputs, and input changes after capture,
    // must not disturb the transform in flight.
    task automatic test_ignore_start();
        int ndone = 0;
        apply_inputs(0);
        start = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            checks++;
            if (busy !== (k <= 5) || done !== (k == 5)) begin
                failures++;
                $display("FAIL ignore_ctrl cycle %0d busy=%b done=%b required %b %b",
                         k, busy, done, (k <= 5), (k == 5));
            end
            if (done === 1'b1) ndone++;
            if (k == 5) begin
                for (int i = 0; i < 8; i++) begin
                    checks++;
                    if (x_real[i] !== vexp_re[0][i] || x_imag[i] !== vexp_im[0][i]) begin
                        failures++;
                        $display("FAIL ignore_out[%0d] got %h/%h required %h/%h",
                                 i, x_real[i], x_imag[i], vexp_re[0][i], vexp_im[0][i]);
                    end
                end
            end
            if (k == 1) begin
                start = 1'b0;
                apply_inputs(1);
            end
            if (k == 2) start = 1'b1;
            if (k == 3) start = 1'b0;
        end
        checks++;
        if (ndone != 1) begin
            failures++;
            $display("FAIL ignore_done_count got %0d required 1", ndone);
        end
    endtask

    // Reset in the middle of STAGE1 clears everything at once and kills the run.
    task automatic test_reset_mid();
        int ndone = 0;
        apply_inputs(3);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_busy_before got %b required 1", busy);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_ctrl busy=%b done=%b required 0 0", busy, done);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (x_real[i] !== 16'sh0000 || x_imag[i] !== 16'sh0000) begin
                failures++;
                $display("FAIL rstmid_out[%0d] got %h/%h required 0000/0000",
                         i, x_real[i], x_imag[i]);
            end
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) ndone++;
        end
        checks++;
        if (ndone != 0) begin
            failures++;
            $display("FAIL rstmid_after got %0d active cycles required 0", ndone);
        end
    endtask

    // start present on the very first edge after reset release is honoured.
    task automatic test_reset_release_start();
        int lat;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        run_vec(4, lat);
        checks++;
        if (lat !== 4) begin
            failures++;
            $display("FAIL release_latency got %0d required 4", lat);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (x_real[i] !== vexp_re[4][i] || x_imag[i] !== vexp_im[4][i]) begin
                failures++;
                $display("FAIL release_out[%0d] got %h/%h required %h/%h",
                         i, x_real[i], x_imag[i], vexp_re[4][i], vexp_im[4][i]);
            end
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL release_idle done=%b busy=%b required 0 0", done, busy);
        end
    endtask

    // start held for 20 cycles: accepts at E0, E6, E12 and E18, each with the
    // input set present at that edge.
    task automatic test_back_to_back();
        int order [4] = '{0, 3, 1, 4};
        int ndone = 0;
        int e;
        int m;
        logic exp_done;
        for (int k = 0; k < 30; k++) begin
            if (k > 0) begin
                e        = k - 1;
                exp_done = ((e % 6) == 4) && (e <= 22);
                checks++;
                if (done !== exp_done) begin
                    failures++;
                    $display("FAIL b2b_done after edge %0d got %b required %b",
                             e, done, exp_done);
                end
                if (done === 1'b1) begin
                    ndone++;
                    m = (e / 6 > 3) ? 3 : e / 6;
                    for (int i = 0; i < 8; i++) begin
                        checks++;
                        if (x_real[i] !== vexp_re[order[m]][i] ||
                            x_imag[i] !== vexp_im[order[m]][i]) begin
                            failures++;
                            $display("FAIL b2b_out run %0d [%0d] got %h/%h required %h/%h",
                                     m, i, x_real[i], x_imag[i],
                                     vexp_re[order[m]][i], vexp_im[order[m]][i]);
                        end
                    end
                end
            end
            start = (k < 20);
            m     = (k / 6 > 3) ? 3 : k / 6;
            apply_inputs(order[m]);
            @(negedge clk);
        end
        start = 1'b0;
        checks++;
        if (ndone != 4) begin
            failures++;
            $display("FAIL b2b_done_count got %0d required 4", ndone);
        end
    endtask

    // -------------------------------------------------------------------------
    initial begin
        rst   = 1'b1;
        start = 1'b0;
        init_vectors();
        apply_inputs(0);
        @(negedge clk);
        test_reset();
        test_constant();
        test_dc();
        test_sine();
        test_bin1_floor();
        test_mult_truncation();
        test_wrap();
        test_hold_no_start();
        test_ignore_start();
        test_reset_mid();
        test_reset_release_start();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
